// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_pkg : shared widths, entry type and source encoding for the       |
// |          register-file writeback buffer.              Rev 1.0        |
// +----------------------------------------------------------------------+
package rf_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_wb_fifo : in-order writeback FIFO with youngest-match forwarding. |
// |                                                       Rev 1.0        |
// +----------------------------------------------------------------------+
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  wb_entry_t         push_entry_i,
  output wb_entry_t         head_o,
  output logic              head_valid_o,
  output logic              empty_o,
  output logic              full_o,
  input  logic [ADDR_W-1:0] q_rs1_i,
  input  logic [ADDR_W-1:0] q_rs2_i,
  output logic              fwd1_hit_o,
  output logic [DATA_W-1:0] fwd1_data_o,
  output logic              fwd2_hit_o,
  output logic [DATA_W-1:0] fwd2_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;
  logic             do_push;

  // Vectors below are indexed by age: element 0 is the head, higher is younger.
  wb_entry_t        age_entry [DEPTH];
  logic [DEPTH-1:0] age_valid;
  logic [DEPTH-1:0] match1;
  logic [DEPTH-1:0] match2;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign pop          = !empty_o;
  assign do_push      = push_i && !full_o;
  assign head_valid_o = !empty_o;
  assign head_o       = head_valid_o ? age_entry[0] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: every read is qualified by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign age_entry[k] = mem_q[rd_ptr_q + PTR_W'(k)];
    assign age_valid[k] = (CNT_W'(k) < count_q);
    assign match1[k]    = age_valid[k] && (q_rs1_i != REG_ZERO) && (age_entry[k].rd == q_rs1_i);
    assign match2[k]    = age_valid[k] && (q_rs2_i != REG_ZERO) && (age_entry[k].rd == q_rs2_i);
  end

  always_comb begin
    fwd1_hit_o  = |match1;
    fwd2_hit_o  = |match2;
    fwd1_data_o = '0;
    fwd2_data_o = '0;
    // Ascending age scan: the last (youngest) match overrides older ones.
    for (int k = 0; k < DEPTH; k++) begin
      if (match1[k]) fwd1_data_o = age_entry[k].data;
      if (match2[k]) fwd2_data_o = age_entry[k].data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_writeback_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_writeback_buffer : round-robin ALU/LSU writeback arbiter feeding  |
// |                       the register file through rf_wb_fifo. Rev 1.0  |
// +----------------------------------------------------------------------+
module rf_writeback_buffer
  import rf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic [ADDR_W-1:0] RD,
  output logic              wr_en_RF,
  output logic [DATA_W-1:0] Data_In_RF,
  input  logic [ADDR_W-1:0] q_rs1,
  input  logic [ADDR_W-1:0] q_rs2,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data,
  output logic              empty,
  output logic              full
);

  wb_src_e   prio_q, prio_d;
  logic      grant_alu, grant_lsu;
  logic      push;
  wb_entry_t push_entry;
  wb_entry_t head;
  logic      head_valid;

  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (alu_valid && lsu_valid) begin
      grant_alu = (prio_q == SRC_ALU);
      grant_lsu = (prio_q == SRC_LSU);
    end else begin
      grant_alu = alu_valid;
      grant_lsu = lsu_valid;
    end
  end

  // rst_n gates ready so nothing handshakes while reset is held.
  assign alu_ready = rst_n && !full && grant_alu;
  assign lsu_ready = rst_n && !full && grant_lsu;

  always_comb begin
    prio_d     = prio_q;
    push_entry = {alu_rd, alu_data};
    if (alu_ready) begin
      prio_d = SRC_LSU;
    end else if (lsu_ready) begin
      prio_d     = SRC_ALU;
      push_entry = {lsu_rd, lsu_data};
    end
  end

  // Writes to register 0 complete the handshake but are never buffered.
  assign push = (alu_ready || lsu_ready) && (push_entry.rd != REG_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= SRC_ALU;
    else        prio_q <= prio_d;
  end

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .head_o       (head),
    .head_valid_o (head_valid),
    .empty_o      (empty),
    .full_o       (full),
    .q_rs1_i      (q_rs1),
    .q_rs2_i      (q_rs2),
    .fwd1_hit_o   (fwd1_hit),
    .fwd1_data_o  (fwd1_data),
    .fwd2_hit_o   (fwd2_hit),
    .fwd2_data_o  (fwd2_data)
  );

  assign wr_en_RF   = head_valid;
  assign RD         = head.rd;
  assign Data_In_RF = head.data;

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rf_writeback_buffer : randomized and directed checks against a    |
// |                          queue-based reference model.    Rev 1.0     |
// +----------------------------------------------------------------------+
module tb_rf_writeback_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alu_valid = 1'b0, lsu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_rd = '0, lsu_rd = '0, q_rs1 = '0, q_rs2 = '0;
  logic [DATA_W-1:0] alu_data = '0, lsu_data = '0;
  logic              alu_ready, lsu_ready, wr_en_RF, fwd1_hit, fwd2_hit, empty, full;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] Data_In_RF, fwd1_data, fwd2_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   mprio;  // 0: ALU wins the next tie, 1: LSU wins

  always #5 clk = ~clk;

  rf_writeback_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .RD(RD), .wr_en_RF(wr_en_RF), .Data_In_RF(Data_In_RF),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .empty(empty), .full(full)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd3; lsu_rd = 5'd4;
    #2;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got %b want 0", alu_ready); end
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_lsu_ready got %b want 0", lsu_ready); end
    checks++; if (wr_en_RF !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en_RF); end
    checks++; if (RD !== '0 || Data_In_RF !== '0) begin errors++; $display("FAIL reset_head got %0d/%h want 0/0", RD, Data_In_RF); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", empty, full); end
    checks++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0 || fwd1_data !== '0 || fwd2_data !== '0) begin
      errors++; $display("FAIL reset_fwd got %b/%b want 0/0", fwd1_hit, fwd2_hit);
    end
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_single();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b/%b want 1/0", alu_ready, lsu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wr_en_RF !== 1'b1 || RD !== 5'd5 || Data_In_RF !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_head got %b/%0d/%h want 1/5/deadbeef", wr_en_RF, RD, Data_In_RF);
    end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_nonempty got %b want 0", empty); end
    step();
    checks++; if (empty !== 1'b1 || wr_en_RF !== 1'b0) begin errors++; $display("FAIL single_drained got %b/%b want 1/0", empty, wr_en_RF); end
  endtask

  task automatic test_alternate();
    int ai = 0, li = 0;
    logic [ADDR_W-1:0] got[$];
    int exp_rd [8] = '{1, 17, 2, 18, 3, 19, 4, 20};
    do_reset();
    for (int cyc = 0; cyc < 8; cyc++) begin
      alu_valid = (ai < 4); alu_rd = ADDR_W'(1 + ai);  alu_data = 32'hA000 + ai;
      lsu_valid = (li < 4); lsu_rd = ADDR_W'(17 + li); lsu_data = 32'hB000 + li;
      #1;
      checks++; if (alu_ready !== (cyc % 2 == 0) || lsu_ready !== (cyc % 2 == 1)) begin
        errors++; $display("FAIL alt_grant cyc %0d got %b/%b want %b/%b", cyc, alu_ready, lsu_ready, cyc % 2 == 0, cyc % 2 == 1);
      end
      if (wr_en_RF) got.push_back(RD);
      if (alu_ready) ai++;
      if (lsu_ready) li++;
      step();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (wr_en_RF) got.push_back(RD);
      step();
    end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL alt_count got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== ADDR_W'(exp_rd[i])) begin errors++; $display("FAIL alt_order idx %0d got %0d want %0d", i, got[i], exp_rd[i]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      alu_valid = 1'b1; alu_rd = ADDR_W'(9 + cyc); alu_data = 32'hC000 + cyc;
      #1;
      checks++; if (alu_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL b2b_ready cyc %0d got %b full %b want 1/0", cyc, alu_ready, full); end
      if (cyc > 0) begin
        checks++; if (wr_en_RF !== 1'b1 || RD !== ADDR_W'(8 + cyc)) begin errors++; $display("FAIL b2b_retire cyc %0d got %b/%0d want 1/%0d", cyc, wr_en_RF, RD, 8 + cyc); end
      end
      step();
    end
    alu_valid = 1'b0;
    checks++; if (RD !== 5'd12 || Data_In_RF !== 32'hC003) begin errors++; $display("FAIL b2b_last got %0d/%h want 12/c003", RD, Data_In_RF); end
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", empty); end
  endtask

  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got %b want 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (empty !== 1'b1 || wr_en_RF !== 1'b0) begin errors++; $display("FAIL rd0_dropped got %b/%b want 1/0", empty, wr_en_RF); end
    step();
    checks++; if (wr_en_RF !== 1'b0) begin errors++; $display("FAIL rd0_no_write got %b want 0", wr_en_RF); end
  endtask

  task automatic test_forward();
    q_rs1 = 5'd7; q_rs2 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11;
    #1;
    checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle got %b want 0", fwd1_hit); end
    step();
    alu_data = 32'h22;
    checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h11) begin errors++; $display("FAIL fwd_first got %b/%h want 1/11", fwd1_hit, fwd1_data); end
    checks++; if (fwd2_hit !== 1'b0 || fwd2_data !== '0) begin errors++; $display("FAIL fwd_zero_a got %b/%h want 0/0", fwd2_hit, fwd2_data); end
    step();
    alu_valid = 1'b0;
    checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin errors++; $display("FAIL fwd_second got %b/%h want 1/22", fwd1_hit, fwd1_data); end
    checks++; if (fwd2_hit !== 1'b0) begin errors++; $display("FAIL fwd_zero_b got %b want 0", fwd2_hit); end
    step();
    checks++; if (fwd1_hit !== 1'b0 || fwd1_data !== '0) begin errors++; $display("FAIL fwd_retired got %b/%h want 0/0", fwd1_hit, fwd1_data); end
    q_rs1 = '0;
  endtask

  task automatic test_async_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    step();
    alu_valid = 1'b0;
    checks++; if (wr_en_RF !== 1'b1) begin errors++; $display("FAIL areset_pre got %b want 1", wr_en_RF); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wr_en_RF !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL areset_immediate got %b/%b want 0/1", wr_en_RF, empty); end
    checks++; if (RD !== '0 || Data_In_RF !== '0 || full !== 1'b0) begin errors++; $display("FAIL areset_outputs got %0d/%h/%b want 0/0/0", RD, Data_In_RF, full); end
    alu_valid = 1'b1; lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    #1;
    checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin errors++; $display("FAIL areset_ready got %b/%b want 0/0", alu_ready, lsu_ready); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL areset_tie got %b/%b want 1/0", alu_ready, lsu_ready); end
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_random();
    bit ea, el, mfull, ehit1, ehit2;
    logic [DATA_W-1:0] ed1, ed2;
    do_reset();
    mq.delete();
    mprio = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      q_rs1 = ADDR_W'($urandom_range(0, 7));
      q_rs2 = ADDR_W'($urandom_range(0, 7));
      #1;
      mfull = (mq.size() == DEPTH);
      ea = alu_valid && (!lsu_valid || mprio == 0) && !mfull;
      el = lsu_valid && (!alu_valid || mprio == 1) && !mfull;
      ehit1 = 0; ehit2 = 0; ed1 = '0; ed2 = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!ehit1 && q_rs1 != 0 && mq[i].rd == q_rs1) begin ehit1 = 1; ed1 = mq[i].data; end
        if (!ehit2 && q_rs2 != 0 && mq[i].rd == q_rs2) begin ehit2 = 1; ed2 = mq[i].data; end
      end
      checks++; if (alu_ready !== ea || lsu_ready !== el) begin errors++; $display("FAIL rnd_ready cyc %0d got %b/%b want %b/%b", cyc, alu_ready, lsu_ready, ea, el); end
      checks++; if (empty !== (mq.size() == 0) || full !== mfull) begin errors++; $display("FAIL rnd_flags cyc %0d got %b/%b want %b/%b", cyc, empty, full, mq.size() == 0, mfull); end
      checks++; if (wr_en_RF !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_wr_en cyc %0d got %b want %b", cyc, wr_en_RF, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (RD !== mq[0].rd || Data_In_RF !== mq[0].data) begin errors++; $display("FAIL rnd_head cyc %0d got %0d/%h want %0d/%h", cyc, RD, Data_In_RF, mq[0].rd, mq[0].data); end
      end
      checks++; if (fwd1_hit !== ehit1 || fwd1_data !== ed1) begin errors++; $display("FAIL rnd_fwd1 cyc %0d got %b/%h want %b/%h", cyc, fwd1_hit, fwd1_data, ehit1, ed1); end
      checks++; if (fwd2_hit !== ehit2 || fwd2_data !== ed2) begin errors++; $display("FAIL rnd_fwd2 cyc %0d got %b/%h want %b/%h", cyc, fwd2_hit, fwd2_data, ehit2, ed2); end
      if (mq.size() != 0) void'(mq.pop_front());
      if (ea) begin
        if (alu_rd != 0) mq.push_back('{rd: alu_rd, data: alu_data});
        mprio = 1;
      end else if (el) begin
        if (lsu_rd != 0) mq.push_back('{rd: lsu_rd, data: lsu_data});
        mprio = 0;
      end
      checks++; if (mq.size() > DEPTH) begin errors++; $display("FAIL rnd_overflow cyc %0d got %0d want <=%0d", cyc, mq.size(), DEPTH); end
      step();
      if (ea || !alu_valid) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd    = ADDR_W'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (el || !lsu_valid) begin
        lsu_valid = ($urandom_range(0, 99) < 60);
        lsu_rd    = ADDR_W'($urandom_range(0, 7));
        lsu_data  = $urandom;
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_single();
    test_alternate();
    test_back_to_back();
    test_rd_zero();
    test_forward();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
